riscv_instr_decoder: RTL and testbench

- Registered instruction decoder for the RV32I core, with M and F (single-precision) subsets.
- Maps a 32-bit instruction word to execute/memory/writeback control fields: ALU opcode, format type, load/store size, branch class, operand selects, and float-register-file flags.
- Sits between the fetch/IF-ID register and the register file / execute stage.

---
 rtl/riscv_instr_decoder_pkg.sv | 100 ++++++++++
 rtl/riscv_instr_decoder_fp_decode.sv | 55 +++++
 rtl/riscv_instr_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_riscv_instr_decoder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_instr_decoder_pkg.sv
// Shared decode vocabulary for riscv_instr_decoder: opcode/funct constants,
// control-field enums, the registered control bundle and operand-select encodings.
package decoder_pkg;

  localparam int ALUOP_W  = 5;
  localparam int TYPE_W   = 3;
  localparam int DTYPE_W  = 3;
  localparam int BRANCH_W = 3;
  localparam int ALUSEL_W = 2;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

  // OP-FP funct7 values already carry fmt = 00 (single precision) in bits 1:0
  localparam logic [6:0] F7_BASE    = 7'h00;
  localparam logic [6:0] F7_ALT     = 7'h20;
  localparam logic [6:0] F7_MULDIV  = 7'h01;
  localparam logic [6:0] F7_FADD    = 7'h00;
  localparam logic [6:0] F7_FSUB    = 7'h04;
  localparam logic [6:0] F7_FMUL    = 7'h08;
  localparam logic [6:0] F7_FDIV    = 7'h0C;
  localparam logic [6:0] F7_FCMP    = 7'h50;
  localparam logic [6:0] F7_FMV_X_W = 7'h70;
  localparam logic [6:0] F7_FMV_W_X = 7'h78;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD    = 5'd0,  ALU_SUB   = 5'd1,  ALU_SLL    = 5'd2,  ALU_SLT   = 5'd3,
    ALU_SLTU   = 5'd4,  ALU_XOR   = 5'd5,  ALU_SRL    = 5'd6,  ALU_SRA   = 5'd7,
    ALU_OR     = 5'd8,  ALU_AND   = 5'd9,  ALU_MUL    = 5'd10, ALU_MULH  = 5'd11,
    ALU_MULHSU = 5'd12, ALU_MULHU = 5'd13, ALU_DIV    = 5'd14, ALU_DIVU  = 5'd15,
    ALU_REM    = 5'd16, ALU_REMU  = 5'd17, ALU_FADD   = 5'd18, ALU_FSUB  = 5'd19,
    ALU_FMUL   = 5'd20, ALU_FDIV  = 5'd21, ALU_FEQ    = 5'd22, ALU_FLT   = 5'd23,
    ALU_FLE    = 5'd24, ALU_FMV   = 5'd25, ALU_PASS_B = 5'd26
  } alu_op_e;

  typedef enum logic [TYPE_W-1:0] {
    TYPE_R = 3'd0, TYPE_I = 3'd1, TYPE_S = 3'd2, TYPE_B = 3'd3, TYPE_U = 3'd4, TYPE_J = 3'd5
  } raw_type_e;

  typedef enum logic [DTYPE_W-1:0] {
    DT_B = 3'd0, DT_H = 3'd1, DT_W = 3'd2, DT_BU = 3'd3, DT_HU = 3'd4
  } d_type_e;

  typedef enum logic [BRANCH_W-1:0] {
    BR_NONE = 3'd0, BR_EQ = 3'd1, BR_NE = 3'd2, BR_LT = 3'd3,
    BR_GE = 3'd4, BR_LTU = 3'd5, BR_GEU = 3'd6
  } branch_e;

  localparam int SEL_IMM_BIT = 0;
  localparam int SEL_PC_BIT  = 1;
  localparam logic [ALUSEL_W-1:0] SEL_REG    = 2'b00;
  localparam logic [ALUSEL_W-1:0] SEL_IMM    = ALUSEL_W'(1) << SEL_IMM_BIT;
  localparam logic [ALUSEL_W-1:0] SEL_PC_IMM = SEL_IMM | (ALUSEL_W'(1) << SEL_PC_BIT);

  typedef struct packed {
    alu_op_e             alu_op;
    raw_type_e           raw_type;
    logic                load;
    d_type_e             d_type;
    logic                mwe;
    logic                rwe;
    branch_e             branch_type;
    logic                jump;
    logic [ALUSEL_W-1:0] alu_sel;
    logic                auipc;
    logic                f_rd;
    logic                f_d1;
    logic                f_d2;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Integer ALU op shared by OP and OP-IMM; alt selects SUB/SRA variants
  function automatic alu_op_e base_alu_op(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_instr_decoder_fp_decode.sv
// fp_decode: combinational OP-FP (single-precision) funct7/funct3 mapping to
// FPU op and float-register-file read/write flags; valid=0 for unsupported forms.
module fp_decode
  import decoder_pkg::*;
(
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  input  logic [4:0] rs2,
  output logic       valid,
  output alu_op_e    alu_op,
  output logic       f_rd,
  output logic       f_d1,
  output logic       f_d2
);

  // Map the OP-FP function fields to an FPU op and register-file sources
  always_comb begin
    valid  = 1'b0;
    alu_op = ALU_ADD;
    f_rd   = 1'b0;
    f_d1   = 1'b0;
    f_d2   = 1'b0;
    case (funct7)
      F7_FADD, F7_FSUB, F7_FMUL, F7_FDIV: begin
        valid  = 1'b1;
        alu_op = alu_op_e'(5'd18 + {3'b000, funct7[3:2]});
        f_rd   = 1'b1;
        f_d1   = 1'b1;
        f_d2   = 1'b1;
      end
      F7_FCMP: begin
        f_d1 = 1'b1;
        f_d2 = 1'b1;
        case (funct3)
          3'b010: begin valid = 1'b1; alu_op = ALU_FEQ; end
          3'b001: begin valid = 1'b1; alu_op = ALU_FLT; end
          3'b000: begin valid = 1'b1; alu_op = ALU_FLE; end
          default: valid = 1'b0;
        endcase
      end
      F7_FMV_X_W: begin
        valid  = (funct3 == 3'b000) && (rs2 == 5'd0);
        alu_op = ALU_FMV;
        f_d1   = 1'b1;
      end
      F7_FMV_W_X: begin
        valid  = (funct3 == 3'b000) && (rs2 == 5'd0);
        alu_op = ALU_FMV;
        f_rd   = 1'b1;
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/riscv_instr_decoder.sv
// Registered RV32I(+F, optional M) instruction decoder, one cycle of latency.
// Define DECODER_RV32M_EN to decode the funct7=0x01 MUL/DIV group under OP.
module riscv_instr_decoder
  import decoder_pkg::*;
#(
  parameter int ALUOP_WIDTH       = 5,
  parameter int TYPE_WIDTH        = 3,
  parameter int DTYPE_WIDTH       = 3,
  parameter int BRANCH_TYPE_WIDTH = 3,
  parameter int ALUSELECT_WIDTH   = 2,
  parameter int DATA_WIDTH        = 32,
  parameter int OPCODE_WIDTH      = 7,
  parameter int FUNCT3_WIDTH      = 3,
  parameter int FUNCT7_WIDTH      = 7,
  parameter int FUNCT3_RIGHT      = 12,
  parameter int FUNCT3_LEFT       = FUNCT3_WIDTH - 1 + FUNCT3_RIGHT
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        instr,
  output logic [ALUOP_WIDTH-1:0]       ALUOp,
  output logic [TYPE_WIDTH-1:0]        rawType,
  output logic                         load,
  output logic [DTYPE_WIDTH-1:0]       dType,
  output logic                         MWE,
  output logic                         RWE,
  output logic [BRANCH_TYPE_WIDTH-1:0] branchType,
  output logic                         jump,
  output logic [ALUSELECT_WIDTH-1:0]   ALUSelect,
  output logic                         auipcBit,
  output logic                         f_rd,
  output logic                         f_d1,
  output logic                         f_d2
);

  logic [OPCODE_WIDTH-1:0] opcode_s;
  logic [FUNCT3_WIDTH-1:0] funct3_s;
  logic [FUNCT7_WIDTH-1:0] funct7_s;
  logic [4:0]              rs2_s;
  logic                    shift_alt_s;
  logic                    unused_s;
  logic                    legal_s;
  logic                    fp_valid_s;
  alu_op_e                 fp_alu_op_s;
  logic                    fp_rd_s;
  logic                    fp_d1_s;
  logic                    fp_d2_s;
  ctrl_t                   dec_s;
  ctrl_t                   ctrl_s;
  ctrl_t                   ctrl_r;

  assign opcode_s    = instr[OPCODE_WIDTH-1:0];
  assign funct3_s    = instr[FUNCT3_LEFT:FUNCT3_RIGHT];
  assign funct7_s    = instr[DATA_WIDTH-1 -: FUNCT7_WIDTH];
  assign rs2_s       = instr[24:20];
  assign shift_alt_s = (funct3_s == 3'b101) ? instr[30] : 1'b0;
  assign unused_s    = ^{instr[19:15], instr[11:7]};

  fp_decode u_fp_decode (
    .funct7 (funct7_s),
    .funct3 (funct3_s),
    .rs2    (rs2_s),
    .valid  (fp_valid_s),
    .alu_op (fp_alu_op_s),
    .f_rd   (fp_rd_s),
    .f_d1   (fp_d1_s),
    .f_d2   (fp_d2_s)
  );

  // Per-opcode control decode; legal_s drops to 0 for any unsupported encoding
  always_comb begin
    dec_s   = CTRL_BUBBLE;
    legal_s = 1'b1;
    case (opcode_s)
      OPC_OP: begin
        dec_s.raw_type = TYPE_R;
        dec_s.rwe      = 1'b1;
        if (funct7_s == F7_BASE) begin
          dec_s.alu_op = base_alu_op(funct3_s, 1'b0);
        end else if (funct7_s == F7_ALT && (funct3_s == 3'b000 || funct3_s == 3'b101)) begin
          dec_s.alu_op = base_alu_op(funct3_s, 1'b1);
`ifdef DECODER_RV32M_EN
        end else if (funct7_s == F7_MULDIV) begin
          dec_s.alu_op = alu_op_e'(5'd10 + {2'b00, funct3_s});
`else
        end else if (funct7_s == F7_MULDIV) begin
          legal_s = 1'b0;
`endif
        end else begin
          legal_s = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        dec_s.raw_type = TYPE_I;
        dec_s.alu_sel  = SEL_IMM;
        dec_s.rwe      = 1'b1;
        dec_s.alu_op   = base_alu_op(funct3_s, shift_alt_s);
      end
      OPC_LOAD, OPC_LOAD_FP: begin
        dec_s.raw_type = TYPE_I;
        dec_s.load     = 1'b1;
        dec_s.alu_sel  = SEL_IMM;
        dec_s.rwe      = 1'b1;
        dec_s.f_rd     = (opcode_s == OPC_LOAD_FP);
        case (funct3_s)
          3'b000:  dec_s.d_type = DT_B;
          3'b001:  dec_s.d_type = DT_H;
          3'b010:  dec_s.d_type = DT_W;
          3'b100:  dec_s.d_type = DT_BU;
          3'b101:  dec_s.d_type = DT_HU;
          default: legal_s = 1'b0;
        endcase
        if (opcode_s == OPC_LOAD_FP && funct3_s != 3'b010) begin
          legal_s = 1'b0;
        end else begin
          dec_s.alu_op = ALU_ADD;
        end
      end
      OPC_STORE, OPC_STORE_FP: begin
        dec_s.raw_type = TYPE_S;
        dec_s.mwe      = 1'b1;
        dec_s.alu_sel  = SEL_IMM;
        dec_s.f_d2     = (opcode_s == OPC_STORE_FP);
        case (funct3_s)
          3'b000:  dec_s.d_type = DT_B;
          3'b001:  dec_s.d_type = DT_H;
          3'b010:  dec_s.d_type = DT_W;
          default: legal_s = 1'b0;
        endcase
        if (opcode_s == OPC_STORE_FP && funct3_s != 3'b010) begin
          legal_s = 1'b0;
        end else begin
          dec_s.alu_op = ALU_ADD;
        end
      end
      OPC_BRANCH: begin
        dec_s.raw_type = TYPE_B;
        dec_s.alu_op   = ALU_SUB;
        case (funct3_s)
          3'b000:  dec_s.branch_type = BR_EQ;
          3'b001:  dec_s.branch_type = BR_NE;
          3'b100:  dec_s.branch_type = BR_LT;
          3'b101:  dec_s.branch_type = BR_GE;
          3'b110:  dec_s.branch_type = BR_LTU;
          3'b111:  dec_s.branch_type = BR_GEU;
          default: legal_s = 1'b0;
        endcase
      end
      OPC_JAL: begin
        dec_s.raw_type = TYPE_J;
        dec_s.jump     = 1'b1;
        dec_s.rwe      = 1'b1;
        dec_s.alu_sel  = SEL_PC_IMM;
      end
      OPC_JALR: begin
        dec_s.raw_type = TYPE_I;
        dec_s.jump     = 1'b1;
        dec_s.rwe      = 1'b1;
        dec_s.alu_sel  = SEL_IMM;
        if (funct3_s == 3'b000) begin
          legal_s = 1'b1;
        end else begin
          legal_s = 1'b0;
        end
      end
      OPC_LUI: begin
        dec_s.raw_type = TYPE_U;
        dec_s.alu_op   = ALU_PASS_B;
        dec_s.alu_sel  = SEL_IMM;
        dec_s.rwe      = 1'b1;
      end
      OPC_AUIPC: begin
        dec_s.raw_type = TYPE_U;
        dec_s.alu_sel  = SEL_PC_IMM;
        dec_s.auipc    = 1'b1;
        dec_s.rwe      = 1'b1;
      end
      OPC_OP_FP: begin
        dec_s.raw_type = TYPE_R;
        dec_s.rwe      = 1'b1;
        dec_s.alu_op   = fp_alu_op_s;
        dec_s.f_rd     = fp_rd_s;
        dec_s.f_d1     = fp_d1_s;
        dec_s.f_d2     = fp_d2_s;
        legal_s        = fp_valid_s;
      end
      default: legal_s = 1'b0;
    endcase
  end

  assign ctrl_s = legal_s ? dec_s : CTRL_BUBBLE;

  // Control register: reset or an illegal word yields an all-zero bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_r <= CTRL_BUBBLE;
    end else begin
      ctrl_r <= ctrl_s;
    end
  end

  assign ALUOp      = ALUOP_WIDTH'(ctrl_r.alu_op);
  assign rawType    = TYPE_WIDTH'(ctrl_r.raw_type);
  assign load       = ctrl_r.load;
  assign dType      = DTYPE_WIDTH'(ctrl_r.d_type);
  assign MWE        = ctrl_r.mwe;
  assign RWE        = ctrl_r.rwe;
  assign branchType = BRANCH_TYPE_WIDTH'(ctrl_r.branch_type);
  assign jump       = ctrl_r.jump;
  assign ALUSelect  = ALUSELECT_WIDTH'(ctrl_r.alu_sel);
  assign auipcBit   = ctrl_r.auipc;
  assign f_rd       = ctrl_r.f_rd;
  assign f_d1       = ctrl_r.f_d1;
  assign f_d2       = ctrl_r.f_d2;

endmodule

// File: tb/tb_riscv_instr_decoder.sv
// Self-checking bench for riscv_instr_decoder: directed vector table, reset and
// bubble sequences, then random words checked against an ISA-level reference model.
module tb_riscv_instr_decoder;

`ifdef DECODER_RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] aluop;
    logic [2:0] rtype;
    logic       load;
    logic [2:0] dtype;
    logic       mwe;
    logic       rwe;
    logic [2:0] br;
    logic       jump;
    logic [1:0] sel;
    logic       auipc;
    logic       frd;
    logic       fd1;
    logic       fd2;
  } out_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    out_t        exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic [4:0]  alu_op;
  logic [2:0]  raw_type;
  logic        load;
  logic [2:0]  d_type;
  logic        mwe;
  logic        rwe;
  logic [2:0]  branch_type;
  logic        jump;
  logic [1:0]  alu_select;
  logic        auipc_bit;
  logic        f_rd;
  logic        f_d1;
  logic        f_d2;

  int total;
  int bad;

  riscv_instr_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .ALUOp      (alu_op),
    .rawType    (raw_type),
    .load       (load),
    .dType      (d_type),
    .MWE        (mwe),
    .RWE        (rwe),
    .branchType (branch_type),
    .jump       (jump),
    .ALUSelect  (alu_select),
    .auipcBit   (auipc_bit),
    .f_rd       (f_rd),
    .f_d1       (f_d1),
    .f_d2       (f_d2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk(input int aluop, input int rtype, input bit ld, input int dtype,
                              input bit mw, input bit rw, input int br, input bit jmp,
                              input int sel, input bit au, input bit frd, input bit fd1,
                              input bit fd2);
    out_t o;
    o.aluop = 5'(aluop);
    o.rtype = 3'(rtype);
    o.load  = ld;
    o.dtype = 3'(dtype);
    o.mwe   = mw;
    o.rwe   = rw;
    o.br    = 3'(br);
    o.jump  = jmp;
    o.sel   = 2'(sel);
    o.auipc = au;
    o.frd   = frd;
    o.fd1   = fd1;
    o.fd2   = fd2;
    return o;
  endfunction

  // ISA-level reference: mnemonic tables indexed by the instruction fields
  function automatic out_t ref_model(input logic [31:0] w);
    int   base_op[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int   op  = int'(w[6:0]);
    int   f3  = int'(w[14:12]);
    int   f7  = int'(w[31:25]);
    bit   rs2z = (w[24:20] == 5'd0);
    out_t z = '0;
    case (op)
      'h33: begin
        if (f7 == 0) return mk(base_op[f3], 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        if (f7 == 'h20 && f3 == 0) return mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        if (f7 == 'h20 && f3 == 5) return mk(7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        if (f7 == 1 && M_EN) return mk(10 + f3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        return z;
      end
      'h13: return mk((f3 == 5 && w[30]) ? 7 : base_op[f3], 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      'h03: begin
        if (f3 == 3 || f3 > 5) return z;
        return mk(0, 1, 1, (f3 < 3) ? f3 : f3 - 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      end
      'h07: return (f3 == 2) ? mk(0, 1, 1, 2, 0, 1, 0, 0, 1, 0, 1, 0, 0) : z;
      'h23: return (f3 < 3) ? mk(0, 2, 0, f3, 1, 0, 0, 0, 1, 0, 0, 0, 0) : z;
      'h27: return (f3 == 2) ? mk(0, 2, 0, 2, 1, 0, 0, 0, 1, 0, 0, 0, 1) : z;
      'h63: begin
        if (f3 == 2 || f3 == 3) return z;
        return mk(1, 3, 0, 0, 0, 0, (f3 < 2) ? f3 + 1 : f3 - 1, 0, 0, 0, 0, 0, 0);
      end
      'h6F: return mk(0, 5, 0, 0, 0, 1, 0, 1, 3, 0, 0, 0, 0);
      'h67: return (f3 == 0) ? mk(0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0) : z;
      'h37: return mk(26, 4, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      'h17: return mk(0, 4, 0, 0, 0, 1, 0, 0, 3, 1, 0, 0, 0);
      'h53: begin
        if (f7 == 0 || f7 == 4 || f7 == 8 || f7 == 12)
          return mk(18 + f7 / 4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1);
        if (f7 == 'h50 && f3 <= 2) return mk(24 - f3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        if (f7 == 'h70 && f3 == 0 && rs2z) return mk(25, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        if (f7 == 'h78 && f3 == 0 && rs2z) return mk(25, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        return z;
      end
      default: return z;
    endcase
  endfunction

  function automatic out_t got_now();
    return {alu_op, raw_type, load, d_type, mwe, rwe, branch_type, jump,
            alu_select, auipc_bit, f_rd, f_d1, f_d2};
  endfunction

  task automatic check(input string name, input logic [31:0] w, input out_t exp);
    out_t got = got_now();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: instr=%08h got=%06h expected=%06h", name, w, got, exp);
    end
  endtask

  // Present one word (and reset level) before an edge, then sample just after it
  task automatic step(input logic [31:0] w, input logic rst);
    @(negedge clk);
    instr = w;
    reset = rst;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];
  logic [6:0] opc_list[12] = '{7'h33, 7'h13, 7'h03, 7'h07, 7'h23, 7'h27,
                               7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h53};
  logic [6:0] f7_list[9] = '{7'h00, 7'h20, 7'h01, 7'h04, 7'h08, 7'h0C, 7'h50, 7'h70, 7'h78};

  initial begin
    out_t zero = '0;
    out_t div_exp = M_EN ? mk(14, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0) : zero;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    instr = 32'h0000_0000;

    vecs.push_back('{"add",     32'h002081B3, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"slt",     32'h0020A1B3, mk(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"flt_s",   32'hA02091D3, mk(23, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1)});
    vecs.push_back('{"fmv_w_x", 32'hF00081D3, mk(25, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0)});
    vecs.push_back('{"fmv_x_w", 32'hE00081D3, mk(25, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{"fadd_s",  32'h002081D3, mk(18, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1)});
    vecs.push_back('{"fadd_d",  32'h022081D3, zero});
    vecs.push_back('{"div",     32'h0220C1B3, div_exp});
    vecs.push_back('{"sub_f3",  32'h402091B3, zero});
    vecs.push_back('{"lw",      32'h0040A183, mk(0, 1, 1, 2, 0, 1, 0, 0, 1, 0, 0, 0, 0)});
    vecs.push_back('{"lhu",     32'h0000D183, mk(0, 1, 1, 4, 0, 1, 0, 0, 1, 0, 0, 0, 0)});
    vecs.push_back('{"flw",     32'h0000A187, mk(0, 1, 1, 2, 0, 1, 0, 0, 1, 0, 1, 0, 0)});
    vecs.push_back('{"sb",      32'h00208023, mk(0, 2, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0)});
    vecs.push_back('{"sh",      32'h00209023, mk(0, 2, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0)});
    vecs.push_back('{"fsw",     32'h0020A027, mk(0, 2, 0, 2, 1, 0, 0, 0, 1, 0, 0, 0, 1)});
    vecs.push_back('{"beq",     32'h00208063, mk(1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"bgeu",    32'h0020F063, mk(1, 3, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"br_010",  32'h0020A063, zero});
    vecs.push_back('{"jal",     32'h000000EF, mk(0, 5, 0, 0, 0, 1, 0, 1, 3, 0, 0, 0, 0)});
    vecs.push_back('{"jalr",    32'h000100E7, mk(0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0)});
    vecs.push_back('{"lui",     32'h123451B7, mk(26, 4, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0)});
    vecs.push_back('{"auipc",   32'h00001197, mk(0, 4, 0, 0, 0, 1, 0, 0, 3, 1, 0, 0, 0)});
    vecs.push_back('{"srai",    32'h4030D193, mk(7, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0)});
    vecs.push_back('{"addi_b30", 32'h40008193, mk(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0)});
    vecs.push_back('{"zero",    32'h00000000, zero});

    step(32'h002081B3, 1'b1);
    step(32'h002081B3, 1'b1);
    check("reset_add", 32'h002081B3, zero);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].instr, 1'b0);
      check(vecs[i].name, vecs[i].instr, vecs[i].exp);
    end

    // Reset must override a legal decode on the same edge
    step(32'h0020A1B3, 1'b0);
    check("pre_reset_slt", 32'h0020A1B3, mk(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(32'h0020A1B3, 1'b1);
    check("reset_override", 32'h0020A1B3, zero);

    // Bubble then ADD on consecutive cycles
    step(32'h00000000, 1'b0);
    check("bubble_cyc1", 32'h00000000, zero);
    step(32'h002081B3, 1'b0);
    check("add_cyc2", 32'h002081B3, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    for (int n = 0; n < 400; n++) begin
      logic [31:0] w = $urandom();
      int k = $urandom_range(0, 12);
      int j = $urandom_range(0, 9);
      if (k < 12) w[6:0] = opc_list[k];
      if (j < 9) w[31:25] = f7_list[j];
      if ($urandom_range(0, 1) == 0) w[24:20] = 5'd0;
      step(w, 1'b0);
      check("random", w, ref_model(w));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
